// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI4-Lite initiator.
package axil_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    // Unprivileged, secure, data access; non-bufferable, non-cacheable.
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } axil_mst_state_t;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite initiator: runs one single-beat read or write per local command
// and hands back data and response status. Every output comes from a flop.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_REQ  | AW and W offered; each drops after its own handshake
// ST_WR_RESP | bready high, waiting for bvalid
// ST_RD_REQ  | arvalid high, waiting for arready
// ST_RD_RESP | rready high, waiting for rvalid
// ST_DONE    | rsp_valid high with stable payload, waiting for rsp_ready
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  arst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,
    output logic [3:0]            awcache,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,
    output logic [3:0]            arcache,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    // Clears the byte offset so the bus only ever sees word addresses.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    axil_mst_state_t state;
    logic            aw_done;
    logic            w_done;
    logic            aw_hs;
    logic            w_hs;

    assign awprot  = AXI_PROT_DEFAULT;
    assign arprot  = AXI_PROT_DEFAULT;
    assign awcache = AXI_CACHE_DEFAULT;
    assign arcache = AXI_CACHE_DEFAULT;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Transaction sequencer; all channel and response outputs are registered here.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            awaddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= AXI_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr & ALIGN_MASK;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= ST_WR_REQ;
                        end else begin
                            araddr  <= cmd_addr & ALIGN_MASK;
                            arvalid <= 1'b1;
                            state   <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Either channel may finish first; a same-cycle pair counts too.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready <= 1'b1;
                        state  <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_data  <= '0;
                        rsp_resp  <= bresp;
                        state     <= ST_DONE;
                    end
                end

                ST_RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_RESP;
                    end
                end

                ST_RD_RESP: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_data  <= rdata;
                        rsp_resp  <= rresp;
                        state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: a bus-level slave with adjustable stall knobs, a
// transaction-level model of what the initiator must show on every cycle,
// and a directed sequence with hand-computed results.
module tb_axil_master;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  awcache, arcache, wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;

    axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awcache(awcache), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arcache(arcache), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- slave knobs and storage ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit          b_hold = 0;
    logic [1:0]  slv_resp = 2'b00;
    logic [31:0] slv_mem [16];
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit          s_aw_got = 0, s_w_got = 0, s_ar_got = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;

    // ---------------- transaction model ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] data;
        logic [1:0]  resp;
    } txn_t;

    txn_t        exp_q [$];
    txn_t        cur;
    logic [31:0] mdl_mem [16];
    bit m_busy = 0, m_aw = 0, m_w = 0, m_aw_done = 0, m_w_done = 0;
    bit m_b = 0, m_ar = 0, m_r = 0, m_rsp = 0;
    bit prev_arst = 1;
    int aw_cycles = 0, w_cycles = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = '0;
            mdl_mem[i] = '0;
        end
    end

    // Slave response and per-cycle comparison against the model, all at the falling edge.
    always @(negedge aclk) begin
        // slave: responses depend only on handshakes from earlier cycles
        if (arst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
        end else begin
            bvalid  = s_aw_got && s_w_got && !b_hold;
            bresp   = slv_resp;
            rvalid  = s_ar_got;
            rdata   = slv_mem[s_araddr[5:2]];
            rresp   = slv_resp;
            awready = awvalid && !s_aw_got && (aw_wait >= aw_dly);
            wready  = wvalid && !s_w_got && (w_wait >= w_dly);
            arready = arvalid && !s_ar_got && (ar_wait >= ar_dly);
            if (awvalid && !awready) aw_wait++;
            if (wvalid && !wready) w_wait++;
            if (arvalid && !arready) ar_wait++;
            if (bvalid && bready) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) slv_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                s_aw_got = 0;
                s_w_got  = 0;
            end
            if (rvalid && rready) s_ar_got = 0;
            if (awvalid && awready) begin s_aw_got = 1; s_awaddr = awaddr; aw_wait = 0; end
            if (wvalid && wready) begin s_w_got = 1; s_wdata = wdata; s_wstrb = wstrb; w_wait = 0; end
            if (arvalid && arready) begin s_ar_got = 1; s_araddr = araddr; ar_wait = 0; end
        end

        // compare what the initiator shows this cycle with what must be shown
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !prev_arst));
        chk("awvalid", 32'(awvalid), 32'(m_aw));
        chk("wvalid", 32'(wvalid), 32'(m_w));
        chk("bready", 32'(bready), 32'(m_b));
        chk("arvalid", 32'(arvalid), 32'(m_ar));
        chk("rready", 32'(rready), 32'(m_r));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        if (m_aw) chk("awaddr", awaddr, cur.addr);
        if (m_w) begin
            chk("wdata", wdata, cur.wdata);
            chk("wstrb", 32'(wstrb), 32'(cur.wstrb));
        end
        if (m_ar) chk("araddr", araddr, cur.addr);
        if (m_rsp && exp_q.size() > 0) begin
            chk("rsp_write", 32'(rsp_write), 32'(exp_q[0].wr));
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("rsp_resp", 32'(rsp_resp), 32'(exp_q[0].resp));
        end
        if (awvalid) aw_cycles++;
        if (wvalid) w_cycles++;

        // advance the model using this cycle's handshakes
        if (arst) begin
            m_busy = 0; m_aw = 0; m_w = 0; m_aw_done = 0; m_w_done = 0;
            m_b = 0; m_ar = 0; m_r = 0; m_rsp = 0;
            exp_q.delete();
        end else begin
            if (awvalid && awready) begin m_aw = 0; m_aw_done = 1; end
            if (wvalid && wready) begin m_w = 0; m_w_done = 1; end
            if (bvalid && bready) begin m_b = 0; m_rsp = 1; end
            if (m_aw_done && m_w_done) begin m_aw_done = 0; m_w_done = 0; m_b = 1; end
            if (arvalid && arready) begin m_ar = 0; m_r = 1; end
            if (rvalid && rready) begin m_r = 0; m_rsp = 1; end
            if (rsp_valid && rsp_ready) begin
                m_rsp  = 0;
                m_busy = 0;
                if (exp_q.size() > 0) begin
                    if (exp_q[0].wr)
                        for (int b = 0; b < 4; b++)
                            if (exp_q[0].wstrb[b])
                                mdl_mem[exp_q[0].addr[5:2]][8*b +: 8] = exp_q[0].wdata[8*b +: 8];
                    exp_q.delete(0);
                end
            end
            if (cmd_valid && cmd_ready) begin
                m_busy    = 1;
                cur.wr    = cmd_write;
                cur.addr  = {cmd_addr[31:2], 2'b00};
                cur.wdata = cmd_wdata;
                cur.wstrb = cmd_wstrb;
                cur.data  = cmd_write ? 32'h0 : mdl_mem[cmd_addr[5:2]];
                cur.resp  = slv_resp;
                exp_q.push_back(cur);
                if (cmd_write) begin m_aw = 1; m_w = 1; end
                else m_ar = 1;
                aw_cycles = 0;
                w_cycles  = 0;
            end
        end
        prev_arst = arst;
    end

    // ---------------- directed sequence ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] ws, output bit ok);
        bit hs = 0;
        step();
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge aclk);
            hs = cmd_ready;
            step();
        end
        cmd_valid = 0;
        ok = hs;
        if (!hs) timeout("cmd_accept");
    endtask

    // Returns at the falling edge of the first cycle rsp_valid is seen.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic c1_valid, output logic [31:0] c1_addr,
                          output int lat, output logic [31:0] r_data, output logic [1:0] r_resp,
                          output logic r_write);
        bit ok;
        issue_cmd(wr, addr, wd, ws, ok);
        @(negedge aclk);
        c1_valid = wr ? (awvalid && wvalid) : arvalid;
        c1_addr  = wr ? awaddr : araddr;
        lat = -1;
        for (int n = 1; n < 60; n++) begin
            if (rsp_valid) begin
                lat = n;
                break;
            end
            @(negedge aclk);
        end
        if (lat < 0) timeout("rsp_wait");
        r_data  = rsp_data;
        r_resp  = rsp_resp;
        r_write = rsp_write;
    endtask

    logic        c1v, rw;
    logic [31:0] c1a, rd;
    logic [1:0]  rr;
    int          lat;
    bit          ok, seen;

    initial begin
        repeat (3) step();
        @(negedge aclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("prot_cache", 32'({awprot, arprot, awcache, arcache}), 32'h0);
        step();
        arst = 0;
        step();
        @(negedge aclk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // read of untouched location
        do_cmd(0, 32'h8, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("rd0_arvalid_c1", 32'(c1v), 32'h1);
        chk("rd0_araddr", c1a, 32'h8);
        chk("rd0_lat", 32'(lat), 32'd3);
        chk("rd0_data", rd, 32'h0);
        chk("rd0_resp", 32'(rr), 32'h0);
        chk("rd0_write", 32'(rw), 32'h0);

        // write then read back
        do_cmd(1, 32'h8, 32'h0000001F, 4'hF, c1v, c1a, lat, rd, rr, rw);
        chk("wr1_valid_c1", 32'(c1v), 32'h1);
        chk("wr1_awaddr", c1a, 32'h8);
        chk("wr1_lat", 32'(lat), 32'd3);
        chk("wr1_resp", 32'(rr), 32'h0);
        chk("wr1_write", 32'(rw), 32'h1);
        chk("wr1_data", rd, 32'h0);
        do_cmd(0, 32'h8, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("rd1_data", rd, 32'h0000001F);

        // unaligned address, partial strobes
        do_cmd(1, 32'hB, 32'hA5A51234, 4'b0011, c1v, c1a, lat, rd, rr, rw);
        chk("wr2_awaddr_aligned", c1a, 32'h8);
        do_cmd(0, 32'h8, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("rd2_data_merged", rd, 32'h00001234);

        // awready stalled three cycles, wready immediate
        step();
        aw_dly = 3;
        do_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, c1v, c1a, lat, rd, rr, rw);
        chk("bp_aw_lat", 32'(lat), 32'd6);
        chk("bp_aw_cycles", 32'(aw_cycles), 32'd4);
        chk("bp_w_cycles", 32'(w_cycles), 32'd1);

        // wready stalled two cycles, awready immediate
        step();
        aw_dly = 0;
        w_dly = 2;
        do_cmd(1, 32'h14, 32'h0BADF00D, 4'b1100, c1v, c1a, lat, rd, rr, rw);
        chk("bp_w_lat", 32'(lat), 32'd5);
        chk("bp_w_aw_cycles", 32'(aw_cycles), 32'd1);
        chk("bp_w_w_cycles", 32'(w_cycles), 32'd3);

        // arready stalled two cycles
        step();
        w_dly = 0;
        ar_dly = 2;
        do_cmd(0, 32'h10, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("bp_ar_lat", 32'(lat), 32'd5);
        chk("bp_ar_data", rd, 32'hDEADBEEF);
        step();
        ar_dly = 0;
        do_cmd(0, 32'h14, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("rd_upper_bytes", rd, 32'h0BAD0000);

        // SLVERR with the response held off for five cycles
        step();
        slv_resp = 2'b10;
        rsp_ready = 0;
        do_cmd(0, 32'h10, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("slverr_resp", 32'(rr), 32'h2);
        chk("slverr_data", rd, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rsp_resp", 32'(rsp_resp), 32'h2);
            chk("hold_rsp_data", rsp_data, 32'hDEADBEEF);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'h0);
            chk("hold_no_valid", 32'({awvalid, wvalid, arvalid}), 32'h0);
            @(negedge aclk);
        end
        step();
        rsp_ready = 1;

        // DECERR on a write
        step();
        slv_resp = 2'b11;
        do_cmd(1, 32'h18, 32'h00000001, 4'hF, c1v, c1a, lat, rd, rr, rw);
        chk("decerr_resp", 32'(rr), 32'h3);
        chk("decerr_write", 32'(rw), 32'h1);

        // reset while waiting for the write response
        step();
        slv_resp = 2'b00;
        b_hold = 1;
        issue_cmd(1, 32'h4, 32'h00000055, 4'hF, ok);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            seen = bready;
        end
        if (!seen) timeout("wait_bready");
        step();
        arst = 1;
        step();
        @(negedge aclk);
        chk("midrst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'h0);
        step();
        arst = 0;
        b_hold = 0;
        step();
        @(negedge aclk);
        chk("midrst_release_cmd_ready", 32'(cmd_ready), 32'h1);

        // normal operation resumes
        do_cmd(0, 32'h8, 32'h0, 4'h0, c1v, c1a, lat, rd, rr, rw);
        chk("after_rst_lat", 32'(lat), 32'd3);
        chk("after_rst_data", rd, 32'h00001234);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
